clock_period_meter: RTL and testbench
=====================================

# clock_period_meter

Measures a slow, asynchronous periodic signal such as a divided clock output or an external strobe, against the 50 MHz system clock. It reports the signal's period and high time in system-clock cycles. It is the receiving end of the team's clock-division chain: it checks that a divided clock arrives at the expected rate and duty cycle. It also flags a stalled signal.

## Interface
Parameters:
- CNT_W, 25, width of the cycle counter and of both measurement outputs; covers one full 25,000,000-cycle period of a 2 Hz signal
- TIMEOUT, 30_000_000, number of cycles without a rising edge before a stall is declared; must be ≤ 2^CNT_W−1

Ports:
- clk_in  input  1  50 MHz system clock, all logic on rising edge
- Reset  input  1  asynchronous, active-high reset
- sig_in  input  1  measured signal, asynchronous to clk_in
- period  output  CNT_W  cycles between the last two rising edges; resets to 0
- high_time  output  CNT_W  cycles from the last rise to the following fall; resets to 0
- meas_valid  output  1  one-cycle pulse when period/high_time update; resets to 0
- timeout  output  1  sticky stall flag; resets to 0

## Operation
- Input conditioning:
  - sig_in passes through a 2-FF synchronizer and then a previous-value register.
  - rise = s2 & ~prev; fall = ~s2 & prev.
- Counter cnt:
  - Loads 1 on rise.
  - Otherwise increments each cycle, saturating at 2^CNT_W−1.
- States:
  - IDLE: entered at reset. cnt is held at 0 and falls are ignored. On rise, go to MEASURE and set cnt to 1. No output update in IDLE.
  - MEASURE, on fall: capture hi_cap <= cnt and set fall_seen.
  - MEASURE, on rise: period <= cnt, high_time <= (fall_seen ? hi_cap : 0), pulse meas_valid, clear timeout, clear fall_seen, set cnt to 1.
- The first rise after reset or after a timeout only arms the block. The first valid measurement comes on the second rise.
- period and high_time update together. They are always a coherent pair from the same cycle and hold between updates.
- rise and fall cannot occur in the same cycle, because both come from one synchronized bit.
- Reset mid-operation: all registers, including the synchronizer, clear immediately. The block returns to IDLE.

## Timing
- Latency:
  - An sig_in edge sampled at clk edge k appears as rise or fall in the cycle after edge k+1.
  - State and outputs update at edge k+2.
  - meas_valid is high for exactly one cycle after edge k+2.
- Measured value = clk_in cycles between consecutive rise detections. Synchronizer delay cancels out.
- Minimum measurable input: high and low phases of at least 2 clk_in cycles each. Shorter pulses may be lost.
- meas_valid is a single-cycle pulse with no handshake. The consumer must sample it in that cycle.

## Configuration
- CLOCK_PERIOD_METER_TIMEOUT_EN defined:
  - In MEASURE, when cnt reaches TIMEOUT with no rise: set timeout, go to IDLE, clear cnt and fall_seen.
  - period and high_time keep their last values.
  - timeout stays 1 until the next meas_valid.
- Macro undefined:
  - No timeout logic; the timeout output is tied to 0.
  - cnt saturates at 2^CNT_W−1. The next rise then reports period = 2^CNT_W−1, which software treats as overrange.

## Structure
- Shared package clock_meter_pkg contains:
  - state encoding ST_IDLE = 1'b0, ST_MEASURE = 1'b1
  - default CNT_W
  - default TIMEOUT
- Sub-module edge_sync contains the 2-FF synchronizer, previous-value register and rise/fall pulses. It is clocked by clk_in and reset by Reset. It is reusable by other blocks that take asynchronous inputs.
- The top level contains the FSM, counter, capture registers and the optional timeout.

## Test plan
The bench uses CNT_W=8 and TIMEOUT=100.
- Reset release with sig_in=0 -> all outputs 0, state IDLE. No meas_valid for 50 cycles.
- sig_in period 8 cycles, 4 high / 4 low -> first meas_valid on the 2nd rise with period=8 and high_time=4. The pulse then repeats every 8 cycles.
- sig_in period 10, 3 high / 7 low -> period=10, high_time=3. Then switch to a 20-cycle period with 10 high / 10 low: the first update after the switch shows period=20, high_time=10, with no mixed pair.
- Macro defined, sig_in held high after a valid measurement -> timeout=1 exactly 100 cycles after the last rise, and period keeps its old value. Resume toggling -> timeout clears on the 2nd rise, together with meas_valid.
- Macro undefined, sig_in period 300 -> period=255 at each update and timeout stays 0.
- Reset asserted mid-period for 1 cycle -> outputs 0 immediately. The next rise only arms the block; the first meas_valid comes on the following rise.

Source files
------------

// File: rtl/clock_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and
// default sizing. The defaults cover a 2 Hz signal measured at 50 MHz.
package clock_meter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_t;

    // 25 bits hold one full 25,000,000-cycle period of a 2 Hz input.
    localparam int CNT_W_DEF   = 25;
    // 0.6 s at 50 MHz without a rising edge counts as a stall.
    localparam int TIMEOUT_DEF = 30_000_000;

    // Largest value a CNT_W-bit counter can hold, as a 64-bit number so the
    // range check on TIMEOUT works for any width up to 32 bits.
    function automatic longint cnt_max_value(input int width);
        return (longint'(1) << width) - 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Edge detector for an asynchronous single-bit input.
// Two-flop synchronizer followed by a previous-value register; rise and fall
// are single-cycle pulses derived from the synchronized bit, so they can
// never be high in the same cycle. Reusable for any asynchronous strobe.
module edge_sync (
    input  logic clk_in,
    input  logic Reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    // Synchronize the input and keep the previous synchronized value.
    always_ff @(posedge clk_in or posedge Reset) begin
        if (Reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk_in
// cycles. The first rising edge after reset (or after a stall) only arms the
// meter; each later rising edge publishes the previous cycle's period and
// high time as one coherent pair together with a one-cycle meas_valid pulse.
//
// Optional feature: define CLOCK_PERIOD_METER_TIMEOUT_EN to enable stall
// detection. Without it the timeout output is tied low and a stalled input
// shows up as a saturated period (all ones) at the next rising edge.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for the arming rise; cnt held at 0, falls ignored
// ST_MEASURE | counting cycles since the last rise, capturing high time
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk_in,
    input  logic             Reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A stall threshold the counter cannot reach would never fire.
    if (TIMEOUT < 1 || longint'(TIMEOUT) > cnt_max_value(CNT_W)) begin : g_timeout_range
        $error("clock_period_meter: TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    logic timeout_q;
`endif

    meter_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cap;
    logic             fall_seen;
    logic             rise;
    logic             fall;

    edge_sync u_edge_sync (
        .clk_in   (clk_in),
        .Reset    (Reset),
        .async_in (sig_in),
        .rise     (rise),
        .fall     (fall)
    );

    // Measurement FSM: counter, high-time capture and registered outputs.
    always_ff @(posedge clk_in or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hi_cap     <= '0;
            fall_seen  <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            meas_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state     <= ST_MEASURE;
                        cnt       <= CNT_ONE;
                        fall_seen <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        // Publish both values in the same cycle so a reader
                        // never sees a period from one cycle paired with a
                        // high time from another.
                        period     <= cnt;
                        high_time  <= fall_seen ? hi_cap : '0;
                        meas_valid <= 1'b1;
                        fall_seen  <= 1'b0;
                        cnt        <= CNT_ONE;
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
                        timeout_q  <= 1'b0;
`endif
                    end
`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
                    else if (cnt == TIMEOUT_CNT) begin
                        // Stall: drop back to IDLE so the next rise re-arms;
                        // the last good measurement stays on the outputs.
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        fall_seen <= 1'b0;
                    end
`endif
                    else begin
                        if (fall) begin
                            hi_cap    <= cnt;
                            fall_seen <= 1'b1;
                        end
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter with CNT_W=8, TIMEOUT=100. Stimulus pushes the
// expected measurement (values and arrival cycle) into a queue whenever it
// issues a rising edge that completes a period; a monitor pops and compares
// on every meas_valid pulse.
module tb_clock_period_meter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 100;

    logic             clk;
    logic             reset;
    logic             sig;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;

    typedef struct {
        int per;
        int hi;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   prev_per = 0;
    int   prev_hi = 0;
    bit   prev_valid = 0;

    clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_in     (clk),
        .Reset      (reset),
        .sig_in     (sig),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, actual time %0t, required below 400000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int sat8(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    // Monitor: every meas_valid must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && meas_valid) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_meas_valid: pulse at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("period", int'(period), e.per);
                check("high_time", int'(high_time), e.hi);
                check("valid_cycle", cyc, e.cyc);
                check("timeout_at_valid", int'(timeout), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one rising edge; it completes the previous period if one is open.
    task automatic rise_edge(input int hi, input int lo);
        exp_t e;
        if (prev_valid) begin
            e.per = sat8(prev_per);
            e.hi  = prev_hi;
            e.cyc = cyc + 3;
            q.push_back(e);
        end
        prev_per   = hi + lo;
        prev_hi    = hi;
        prev_valid = 1;
        sig = 1'b1;
    endtask

    task automatic gen(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            rise_edge(hi, lo);
            repeat (hi) tick();
            sig = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (q.size() != 0 && waited < 50) begin
            tick();
            waited++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    task automatic do_reset();
        sig   = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_period", int'(period), 0);
        check("rst_high_time", int'(high_time), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_timeout", int'(timeout), 0);
        reset = 1'b0;
        prev_valid = 0;
        tick();
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        sig   = 1'b0;
        tick();

        // Reset release with a quiet input: nothing may happen.
        do_reset();
        pulses = 0;
        repeat (50) begin
            tick();
            if (meas_valid) pulses++;
        end
        check("idle_no_valid", pulses, 0);
        check("idle_period", int'(period), 0);
        check("idle_high_time", int'(high_time), 0);

        // 8-cycle period, 4 high / 4 low.
        gen(4, 4, 4);
        drain();

        // 10-cycle 3/7, then switch to 20-cycle 10/10 without a gap.
        do_reset();
        gen(3, 7, 3);
        gen(10, 10, 3);
        drain();
        check("hold_period", int'(period), 20);
        check("hold_high_time", int'(high_time), 10);

`ifdef CLOCK_PERIOD_METER_TIMEOUT_EN
        // Stall detection: hold high after a valid measurement.
        begin
            int c0;
            int t_cyc;
            do_reset();
            gen(4, 4, 3);
            rise_edge(4, 4);
            prev_valid = 0;
            c0 = cyc;
            t_cyc = -1;
            for (int i = 0; i < 200 && t_cyc < 0; i++) begin
                tick();
                if (timeout) t_cyc = cyc;
            end
            check("timeout_cycle", t_cyc, c0 + 3 + TIMEOUT);
            check("timeout_period_kept", int'(period), 8);
            check("timeout_high_kept", int'(high_time), 4);
            sig = 1'b0;
            repeat (6) tick();
            check("timeout_sticky", int'(timeout), 1);
            gen(4, 4, 1);
            check("timeout_after_arm", int'(timeout), 1);
            gen(4, 4, 1);
            drain();
            check("timeout_cleared", int'(timeout), 0);
        end
`else
        // Without stall detection a long period saturates at 255.
        do_reset();
        gen(150, 150, 3);
        drain();
        check("sat_period", int'(period), 255);
        check("sat_timeout", int'(timeout), 0);
`endif

        // Reset asserted for one cycle in the middle of a period.
        do_reset();
        gen(5, 5, 2);
        rise_edge(5, 5);
        repeat (5) tick();
        sig = 1'b0;
        repeat (2) tick();
        drain();
        reset = 1'b1;
        #1;
        check("midrst_period", int'(period), 0);
        check("midrst_high_time", int'(high_time), 0);
        check("midrst_meas_valid", int'(meas_valid), 0);
        tick();
        reset = 1'b0;
        prev_valid = 0;
        repeat (3) tick();
        gen(6, 4, 3);
        drain();
        check("post_rst_period", int'(period), 10);
        check("post_rst_high_time", int'(high_time), 6);

        repeat (5) tick();
        check("final_queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
